// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI transfer sequencer.
// FSM encodings, default transfer length and the minimum half-period.
package spi_pkg;

    // Sequencer states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Default bits per transfer and the matching SCLK edge-counter width
    localparam int BITS_DEF   = 8;
    localparam int ECNT_W_DEF = $clog2(2 * BITS_DEF + 1);

    // Shortest legal SCLK half-period in PCLK cycles (baud_div of 0 or 1)
    localparam int H_MIN = 2;

    // Edge-counter width for an arbitrary transfer length
    function automatic int ecnt_w(input int bits);
        return $clog2(2 * bits + 1);
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if: control/status bundle between the register front end
// (master side) and the SPI transfer sequencer (slave side).
interface spi_xfer_ctrl_if #(parameter int DIV_W = 12);

    logic             spe;
    logic             start;
    logic             cpol;
    logic             cpha;
    logic [DIV_W-1:0] baud_div;
    logic             busy;
    logic             done;
    logic             abort;
    logic             ss;
    logic             sclk;
    logic             send_data;
    logic             receive_data;
    logic             flag_low;
    logic             flag_high;
    logic             flags_low;
    logic             flags_high;

    modport master (
        output spe, start, cpol, cpha, baud_div,
        input  busy, done, abort, ss, sclk, send_data, receive_data,
               flag_low, flag_high, flags_low, flags_high
    );

    modport slave (
        input  spe, start, cpol, cpha, baud_div,
        output busy, done, abort, ss, sclk, send_data, receive_data,
               flag_low, flag_high, flags_low, flags_high
    );

endinterface

// File: rtl/spi_baud_gen.sv
// spi_baud_gen: half-period counter and SCLK phase for one transfer.
// The counter runs whenever 'run' is high (SHIFT and the DONE guard);
// SCLK toggles and strobes are produced only while 'tgl_en' is high.
// SCLK is held as a phase relative to cpol_q so it always returns to the
// captured idle level after an even number of toggles.
module spi_baud_gen #(
    parameter int CW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          tgl_en,
    input  logic [CW-1:0] h_q,
    input  logic          cpol_q,
    output logic          sclk,
    output logic          wrap,
    output logic          flag_low,
    output logic          flag_high,
    output logic          flags_low,
    output logic          flags_high
);

    logic [CW-1:0] cnt;
    logic          ph;
    logic          pre;

    assign wrap = (cnt == h_q - CW'(1));
    assign pre  = (cnt == h_q - CW'(2));
    assign sclk = cpol_q ^ ph;

    // Count 0..h_q-1 and flip the SCLK phase on each wrap while shifting
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
            ph  <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (tgl_en && wrap)
                ph <= ~ph;
        end
    end

    // The next SCLK edge direction picks the low/high strobe variant
    assign flag_low   = tgl_en & wrap & sclk;
    assign flag_high  = tgl_en & wrap & ~sclk;
    assign flags_low  = tgl_en & pre  & sclk;
    assign flags_high = tgl_en & pre  & ~sclk;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: master-side SPI transfer sequencer.
// IDLE -> LOAD -> SHIFT (2*BITS SCLK edges) -> DONE (H_q guard cycles).
// Optional macro SPI_CONT_EN: a held request in the last DONE cycle goes
// straight back to LOAD, keeping ss low across back-to-back bytes.
// cpha is not used here; the shift register consumes it directly.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DIV_W = 12,
    parameter int BITS  = BITS_DEF
) (
    input  logic            PCLK,
    input  logic            PRESET,
    spi_xfer_ctrl_if.slave  bus
);

    localparam int CW = DIV_W + 1;
    localparam int EW = $clog2(2 * BITS + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * BITS - 1);

    logic [1:0]    state;
    logic [CW-1:0] h_q;
    logic [CW-1:0] h_in;
    logic [EW-1:0] ecnt;
    logic          cpol_q;
    logic          done_q;
    logic          abort_q;
    logic          wrap;
    logic          sclk_gen;
    logic          cont_go;

    // Half-period from the divisor, with 0 clamped to the minimum
    assign h_in = (bus.baud_div < DIV_W'(H_MIN - 1)) ? CW'(H_MIN)
                                                     : CW'(bus.baud_div) + CW'(1);

`ifdef SPI_CONT_EN
    assign cont_go = bus.spe & bus.start;
`else
    assign cont_go = 1'b0;
`endif

    // Sequencer FSM, edge counter, shadow capture and pulse registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            ecnt    <= '0;
            h_q     <= CW'(H_MIN);
            cpol_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (state != IDLE && !bus.spe) begin
                state   <= IDLE;
                abort_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (bus.spe && bus.start) state <= LOAD;
                    LOAD: begin
                        state  <= SHIFT;
                        ecnt   <= '0;
                        h_q    <= h_in;
                        cpol_q <= bus.cpol;
                    end
                    SHIFT: if (wrap) begin
                        ecnt <= ecnt + EW'(1);
                        if (ecnt == LAST_EDGE) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                    DONE: if (wrap) state <= cont_go ? LOAD : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    spi_baud_gen #(.CW(CW)) u_baud (
        .clk        (PCLK),
        .rst        (PRESET),
        .run        (state == SHIFT || state == DONE),
        .tgl_en     (state == SHIFT),
        .h_q        (h_q),
        .cpol_q     (cpol_q),
        .sclk       (sclk_gen),
        .wrap       (wrap),
        .flag_low   (bus.flag_low),
        .flag_high  (bus.flag_high),
        .flags_low  (bus.flags_low),
        .flags_high (bus.flags_high)
    );

    // Before the shadow is valid SCLK follows the live cpol input
    assign bus.sclk         = (state == IDLE || state == LOAD) ? bus.cpol : sclk_gen;
    assign bus.busy         = (state != IDLE);
    assign bus.ss           = (state == IDLE);
    assign bus.send_data    = (state == LOAD);
    assign bus.receive_data = done_q;
    assign bus.done         = done_q;
    assign bus.abort        = abort_q;

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- Master-side sequencer for the SPI byte shift register.
- Generates SCLK from PCLK using a programmable divisor, drives ss, and issues the send_data/receive_data load/capture pulses.
- Produces the edge strobes flag_low/flag_high and the one-cycle-earlier pre-strobes flags_low/flags_high that the shift register uses to launch MOSI and sample MISO.
- Sits between the register/APB front end and the shift register; one transfer = BITS SCLK periods.

Parameters:
- DIV_W, 12, width of baud_div.
- BITS, 8, bits per transfer; edge counter width is $clog2(2*BITS+1).

Ports:
- PCLK  in  1  system clock.
- PRESET  in  1  reset, synchronous, active-high.
- spe  in  1  SPI enable; low forces IDLE.
- start  in  1  transfer request, level-sensitive, accepted only in IDLE.
- cpol  in  1  SCLK idle level.
- cpha  in  1  clock phase; passed through for shift-register edge selection.
- baud_div  in  DIV_W  half-period select: H = max(baud_div,1)+1 PCLK cycles.
- busy  out  1  high from LOAD through DONE.
- done  out  1  one-cycle pulse, transfer complete.
- abort  out  1  one-cycle pulse, transfer killed by spe drop.
- ss  out  1  slave select, active-low.
- sclk  out  1  SPI clock.
- send_data  out  1  one-cycle load pulse to shift register.
- receive_data  out  1  one-cycle capture pulse to shift register.
- flag_low  out  1  strobe in the last PCLK cycle before sclk falls.
- flag_high  out  1  strobe in the last PCLK cycle before sclk rises.
- flags_low  out  1  strobe one PCLK cycle before flag_low.
- flags_high  out  1  strobe one PCLK cycle before flag_high.

Behaviour:
- Reset (PRESET sampled high on a PCLK edge):
  - State IDLE; counters cleared.
  - ss=1, sclk=cpol, all other outputs 0.
- IDLE:
  - ss=1, sclk tracks cpol, busy=0.
  - spe & start -> LOAD.
- LOAD (1 cycle):
  - ss=0, send_data=1, busy=1.
  - cpol and baud_div captured into shadow registers (cpol_q, H_q); mid-transfer changes to either are ignored.
  - Next state SHIFT; half-period counter and edge counter cleared.
- SHIFT:
  - Half-period counter runs 0..H_q-1. At H_q-1 it wraps, sclk toggles on the next edge, and the edge counter increments.
  - flag_* asserted when counter = H_q-1; flags_* asserted when counter = H_q-2.
  - The low/high variant is chosen by the current sclk level: sclk high -> _low, sclk low -> _high.
  - First edge occurs H_q cycles after entering SHIFT, which gives MOSI a half-period of setup for cpha=0.
  - After edge 2*BITS, go to DONE; sclk is back at cpol_q.
- DONE (H_q cycles, trailing guard):
  - ss=0, sclk=cpol_q, no strobes.
  - receive_data=1 and done=1 in the first DONE cycle only.
  - After the last DONE cycle -> IDLE (ss=1).
- Per-transfer totals:
  - Latency start -> done = 1 + 2*BITS*H_q cycles.
  - busy is high for 1 + 2*BITS*H_q + H_q cycles.
  - Exactly BITS flag_low, BITS flag_high, BITS flags_low and BITS flags_high pulses per transfer.
- Boundaries:
  - start while busy: ignored.
  - baud_div=0: clamped, H=2.
  - spe low in LOAD/SHIFT/DONE: next cycle IDLE, ss=1, sclk=cpol, abort pulses for 1 cycle. No receive_data or done is issued, and no further strobes.
  - PRESET mid-transfer: same as reset, but no abort pulse.
  - start held high continuously: a new transfer begins only after at least one IDLE cycle (ss high for at least 1 cycle).

Optional Feature:
- Macro: SPI_CONT_EN.
- Defined: if spe & start is high in the last DONE cycle, go directly to LOAD. ss stays low across bytes (back-to-back burst), and H_q/cpol_q are recaptured at that LOAD.
- Undefined: DONE always returns to IDLE, and ss deasserts for at least one cycle between bytes.

Decomposition:
- Package spi_pkg:
  - State enum: IDLE, LOAD, SHIFT, DONE.
  - Localparams: BITS default, edge-count width, minimum H = 2.
- One sub-module, spi_baud_gen: holds the half-period counter and sclk toggle, and produces the flag/flags strobes from H_q, cpol_q and an enable.
- The FSM, edge counter and ss/send/receive logic live in the top module.

Test Plan:
1. baud_div=1, cpol=0, cpha=0, start pulse -> send_data 1 cycle after start sampled; first sclk rise 2 cycles into SHIFT; 16 sclk edges; done at cycle 33 after LOAD; busy 35 cycles; 8 each of flag_high/flag_low/flags_high/flags_low.
2. baud_div=3, cpol=1 -> sclk idles 1; first strobe is flags_low then flag_low; half-period 4 cycles; done 65 cycles after LOAD.
3. Mid-transfer: drop spe after edge 5 -> abort pulse, ss=1 and sclk=cpol next cycle; no receive_data, no done.
4. Change cpol and baud_div during SHIFT -> sclk period and polarity unchanged until the next transfer. Assert start during SHIFT -> ignored; no second send_data.
5. baud_div=0 -> behaves identically to baud_div=1. PRESET asserted mid-SHIFT -> all outputs at reset values on the next cycle.
6. start held high:
   - SPI_CONT_EN off: ss high for at least 1 cycle between bytes.
   - SPI_CONT_EN on: ss stays low across 3 bytes, with 3 send_data and 3 done pulses.
